iter_int_mul_param: RTL
=======================

ITER_INT_MUL_PARAM -- requirements
Module: iter_int_mul_param

Interface
REQ-001 SHALL have parameter A_W, default 8, multiplier operand width (>=2).
REQ-002 SHALL have parameter B_W, default 32, multiplicand operand width (>=2).
REQ-003 SHALL have parameter EARLY_TERM, default 0; 1 enables early termination.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 A  input  A_W  multiplier operand.
REQ-007 B  input  B_W  multiplicand operand.
REQ-008 sgn  input  1  1 = both operands two's-complement signed, 0 = both unsigned; sampled with operands.
REQ-009 in_val  input  1  operands valid.
REQ-010 in_rdy  output  1  block can accept operands.
REQ-011 P  output  A_W+B_W  product, registered.
REQ-012 out_val  output  1  P valid.
REQ-013 out_rdy  input  1  consumer accepts P.
REQ-014 busy  output  1  high in CALC or DONE.

Function
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_rdy = (state==IDLE); out_val = (state==DONE); busy = !in_rdy.
REQ-016 IDLE: on in_val && in_rdy, SHALL register a_reg = |A|, b_reg = |B| zero-extended to A_W+B_W, neg = sgn && (A[A_W-1] ^ B[B_W-1]), acc = 0, cnt = 0, go to CALC.
REQ-017 Magnitudes SHALL be taken as unsigned A_W/B_W values (|-2^(A_W-1)| = 2^(A_W-1) fits); for sgn=0 magnitude is the raw operand.
REQ-018 Each CALC cycle: if a_reg[0], acc += b_reg (mod 2^(A_W+B_W)); a_reg >>= 1; b_reg <<= 1; cnt += 1.
REQ-019 EARLY_TERM=0: CALC SHALL last exactly A_W cycles (exit when cnt==A_W-1 in that cycle).
REQ-020 EARLY_TERM=1: CALC SHALL exit after the cycle in which the shifted a_reg becomes 0, or at cnt==A_W-1, whichever first; minimum 1 CALC cycle (A=0 -> 1 cycle).
REQ-021 On CALC exit, P SHALL load neg ? -acc_next : acc_next (two's complement, A_W+B_W bits), state -> DONE.
REQ-022 Latency: out_val SHALL rise N+1 cycles after the accepting edge, N = number of CALC cycles.
REQ-023 DONE: P and out_val SHALL hold stable while out_rdy=0; on out_rdy=1 go to IDLE in the next cycle.
REQ-024 No overlap: in_val while busy SHALL be ignored (not accepted, not queued); A/B/sgn changes during CALC/DONE SHALL not affect P.
REQ-025 P SHALL retain the last product in IDLE until the next CALC exit.
REQ-026 Operand changes only sampled on the accepting edge; in_val deassert after accept has no effect.

Reset
REQ-027 When reset=1 at a rising edge, SHALL force state=IDLE, P=0, acc=0, cnt=0, neg=0, a_reg=0, b_reg=0; hence in_rdy=1, out_val=0, busy=0 next cycle.
REQ-028 Reset SHALL take precedence over all handshakes, including mid-CALC and in DONE (pending result discarded).
REQ-029 First accept SHALL be possible on the first edge after reset deasserts.

Verification (A_W=8, B_W=32)
REQ-030 EARLY_TERM=0, sgn=0, A=3, B=5 accepted at cycle 0 -> out_val rises cycle 9, P=0x000000000F.
REQ-031 sgn=0, A=0xFF, B=0xFFFFFFFF -> P=0xFEFFFFFF01; sgn=1 same operands -> P=0x0000000001.
REQ-032 sgn=1, A=0x80 (-128), B=0x80000000 -> P=0x4000000000; sgn=1, A=0xFE, B=3 -> P=0xFFFFFFFFFA.
REQ-033 EARLY_TERM=1: A=1, B=7 -> out_val at cycle 2, P=7; A=0 -> out_val at cycle 2, P=0; A=0x80 -> cycle 9.
REQ-034 Backpressure: out_rdy=0 for 5 cycles in DONE with in_val=1 -> P, out_val stable, in_rdy=0, no accept; out_rdy=1 -> IDLE next cycle, accept following.
REQ-035 reset=1 during CALC cycle 4 -> next cycle state IDLE, P=0, out_val=0, in_rdy=1; subsequent 3*5 gives 15.

Source files
------------

// File: rtl/iter_int_mul_param.sv
// Iterative shift-and-add integer multiplier, one multiplier bit per cycle.
// Signed operands are reduced to magnitudes on accept, and the product sign
// is applied when the result is loaded.
//
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   A, B, sgn       - operands and signedness, sampled on the accepting edge
//   in_val, in_rdy  - operand handshake (in_rdy high only in IDLE)
//   P, out_val      - registered product and its valid (high only in DONE)
//   out_rdy         - consumer accepts P; DONE -> IDLE on the next edge
//   busy            - high while in CALC or DONE
module iter_int_mul_param #(
    parameter int unsigned A_W        = 8,
    parameter int unsigned B_W        = 32,
    parameter int unsigned EARLY_TERM = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [A_W-1:0]     A,
    input  logic [B_W-1:0]     B,
    input  logic               sgn,
    input  logic               in_val,
    output logic               in_rdy,
    output logic [A_W+B_W-1:0] P,
    output logic               out_val,
    input  logic               out_rdy,
    output logic               busy
);

    localparam int unsigned PW    = A_W + B_W;
    localparam int unsigned CNT_W = $clog2(A_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [A_W-1:0]   a_reg, a_next, a_mag, a_shift;
    logic [B_W-1:0]   b_mag;
    logic [PW-1:0]    b_reg, b_next;
    logic [PW-1:0]    acc, acc_next, acc_sum;
    logic [PW-1:0]    p_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             neg, neg_next;
    logic             calc_last;

    // Operand magnitudes; the most negative value maps to 2^(W-1) unsigned.
    assign a_mag = (sgn && A[A_W-1]) ? (~A + A_W'(1)) : A;
    assign b_mag = (sgn && B[B_W-1]) ? (~B + B_W'(1)) : B;

    // One shift-and-add step and its termination condition.
    assign acc_sum   = a_reg[0] ? (acc + b_reg) : acc;
    assign a_shift   = a_reg >> 1;
    assign calc_last = (cnt == CNT_W'(A_W - 1)) ||
                       ((EARLY_TERM != 0) && (a_shift == '0));

    // Next-state and datapath update.
    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc;
        cnt_next   = cnt;
        neg_next   = neg;
        p_next     = P;
        unique case (state)
            IDLE: begin
                if (in_val) begin
                    a_next     = a_mag;
                    b_next     = PW'(b_mag);
                    neg_next   = sgn && (A[A_W-1] ^ B[B_W-1]);
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                acc_next = acc_sum;
                a_next   = a_shift;
                b_next   = b_reg << 1;
                cnt_next = cnt + CNT_W'(1);
                if (calc_last) begin
                    p_next     = neg ? (~acc_sum + PW'(1)) : acc_sum;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            P       <= '0;
            in_rdy  <= 1'b1;
            out_val <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            a_reg   <= a_next;
            b_reg   <= b_next;
            acc     <= acc_next;
            cnt     <= cnt_next;
            neg     <= neg_next;
            P       <= p_next;
            in_rdy  <= (state_next == IDLE);
            out_val <= (state_next == DONE);
            busy    <= (state_next != IDLE);
        end
    end

endmodule
